// File: rtl/ledmatrix_spi_tx_pkg.sv
// ============================================================================
// ledmatrix_spi_tx_pkg : MAX7219 register map, chain geometry and FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package ledmatrix_spi_tx_pkg;

    localparam int N_DEV   = 4;
    localparam int FRAME_W = 16 * N_DEV;

    localparam logic [7:0] c_ADDR_NOOP      = 8'h00;
    localparam logic [7:0] c_ADDR_DIGIT0    = 8'h01;
    localparam logic [7:0] c_ADDR_DIGIT1    = 8'h02;
    localparam logic [7:0] c_ADDR_DIGIT2    = 8'h03;
    localparam logic [7:0] c_ADDR_DIGIT3    = 8'h04;
    localparam logic [7:0] c_ADDR_DIGIT4    = 8'h05;
    localparam logic [7:0] c_ADDR_DIGIT5    = 8'h06;
    localparam logic [7:0] c_ADDR_DIGIT6    = 8'h07;
    localparam logic [7:0] c_ADDR_DIGIT7    = 8'h08;
    localparam logic [7:0] c_ADDR_DECODE    = 8'h09;
    localparam logic [7:0] c_ADDR_INTENSITY = 8'h0A;
    localparam logic [7:0] c_ADDR_SCANLIMIT = 8'h0B;
    localparam logic [7:0] c_ADDR_SHUTDOWN  = 8'h0C;
    localparam logic [7:0] c_ADDR_TEST      = 8'h0F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2,
        ST_LATCH = 2'd3
    } state_e;

    // Bits needed to hold 0..max_count, never less than one.
    function automatic int cnt_width(input int max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/ledmatrix_spi_tx_if.sv
// ============================================================================
// ledmatrix_spi_tx_if : frame handshake between frame source and transmitter
// Rev 1.0
// ============================================================================
`default_nettype none

interface ledmatrix_spi_tx_if #(
    parameter int WORD_W = 64
);
    logic [WORD_W-1:0] data;
    logic              valid;
    logic              ready;
    logic              busy;
    logic              done;

    modport master (
        output data,
        output valid,
        input  ready,
        input  busy,
        input  done
    );

    modport slave (
        input  data,
        input  valid,
        output ready,
        output busy,
        output done
    );
endinterface

`default_nettype wire

// File: rtl/ledmatrix_sclk_gen.sv
// ============================================================================
// ledmatrix_sclk_gen : half-period counter producing phase_tick and sclk level
// Rev 1.0
// ============================================================================
`default_nettype none

module ledmatrix_sclk_gen
    import ledmatrix_spi_tx_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic en_i,
    input  wire logic toggle_en_i,
    output logic      phase_tick_o,
    output logic      sclk_o
);

    localparam int              CW     = cnt_width(CLK_DIV);
    localparam logic [CW-1:0]   c_TERM = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;

    assign phase_tick_o = en_i && (cnt_q == c_TERM);
    assign sclk_o       = sclk_q;

    // Counter parks at zero while disabled so the first phase is always full length.
    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (!en_i) begin
            cnt_d  = '0;
            sclk_d = 1'b0;
        end else begin
            if (phase_tick_o) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            if (!toggle_en_i) begin
                sclk_d = 1'b0;
            end else if (phase_tick_o) begin
                sclk_d = ~sclk_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/ledmatrix_spi_tx.sv
// ============================================================================
// ledmatrix_spi_tx : shifts one frame MSB-first to a MAX7219 chain, then LOADs
// Rev 1.0
// ============================================================================
`default_nettype none

module ledmatrix_spi_tx
    import ledmatrix_spi_tx_pkg::*;
#(
    parameter int WORD_W  = FRAME_W,
    parameter int CLK_DIV = 2,
    parameter int CS_HIGH = 4
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ledmatrix_spi_tx_if.slave  frm_if,
    output logic               sclk_o,
    output logic               mosi_o,
    output logic               cs_n_o
);

    localparam int            BW           = cnt_width(WORD_W - 1);
    localparam int            LW           = cnt_width(CS_HIGH);
    localparam logic [BW-1:0] c_BIT_TOP    = BW'(WORD_W - 1);
    localparam logic [LW-1:0] c_LATCH_TERM = LW'(CS_HIGH - 1);

    state_e              state_q, state_d;
    logic [WORD_W-1:0]   shreg_q, shreg_d;
    logic [BW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [LW-1:0]       latch_cnt_q, latch_cnt_d;
    logic                cs_n_q, cs_n_d;
    logic                mosi_q, mosi_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                w_phase_tick;
    logic                w_sclk;
    logic                w_bit_end;

    ledmatrix_sclk_gen #(
        .CLK_DIV      (CLK_DIV)
    ) u_sclk_gen (
        .clk          (clk),
        .rst          (rst),
        .en_i         ((state_q == ST_SHIFT) || (state_q == ST_TAIL)),
        .toggle_en_i  (state_q == ST_SHIFT),
        .phase_tick_o (w_phase_tick),
        .sclk_o       (w_sclk)
    );

    // A bit ends when its high phase expires; sclk falls on the same edge mosi moves.
    assign w_bit_end = (state_q == ST_SHIFT) && w_phase_tick && w_sclk;

    always_comb begin
        state_d     = state_q;
        shreg_d     = shreg_q;
        bit_cnt_d   = bit_cnt_q;
        latch_cnt_d = latch_cnt_q;
        cs_n_d      = cs_n_q;
        mosi_d      = mosi_q;
        busy_d      = busy_q;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (frm_if.valid) begin
                    state_d   = ST_SHIFT;
                    shreg_d   = frm_if.data;
                    bit_cnt_d = c_BIT_TOP;
                    cs_n_d    = 1'b0;
                    busy_d    = 1'b1;
                    mosi_d    = frm_if.data[WORD_W-1];
                end
            end
            ST_SHIFT: begin
                if (w_bit_end) begin
                    if (bit_cnt_q == '0) begin
                        state_d = ST_TAIL;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 1'b1;
                        shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
                        mosi_d    = shreg_q[WORD_W-2];
                    end
                end
            end
            ST_TAIL: begin
                if (w_phase_tick) begin
                    state_d     = ST_LATCH;
                    cs_n_d      = 1'b1;
                    done_d      = 1'b1;
                    latch_cnt_d = '0;
                end
            end
            ST_LATCH: begin
                if (latch_cnt_q == c_LATCH_TERM) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    latch_cnt_d = latch_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            latch_cnt_q <= '0;
            cs_n_q      <= 1'b1;
            mosi_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            shreg_q     <= shreg_d;
            bit_cnt_q   <= bit_cnt_d;
            latch_cnt_q <= latch_cnt_d;
            cs_n_q      <= cs_n_d;
            mosi_q      <= mosi_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign frm_if.ready = (state_q == ST_IDLE);
    assign frm_if.busy  = busy_q;
    assign frm_if.done  = done_q;
    assign sclk_o       = w_sclk;
    assign mosi_o       = mosi_q;
    assign cs_n_o       = cs_n_q;

endmodule

`default_nettype wire

// File: tb/tb_ledmatrix_spi_tx.sv
// ============================================================================
// tb_ledmatrix_spi_tx : scoreboard bench for the MAX7219 chain transmitter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_ledmatrix_spi_tx;
    import ledmatrix_spi_tx_pkg::*;

    localparam int WW = 64;
    localparam int CD = 2;
    localparam int CH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ledmatrix_spi_tx_if #(.WORD_W(WW)) ifa ();
    ledmatrix_spi_tx_if #(.WORD_W(WW)) ifb ();

    logic sclk_a, mosi_a, cs_n_a;
    logic sclk_b, mosi_b, cs_n_b;

    ledmatrix_spi_tx #(.WORD_W(WW), .CLK_DIV(CD), .CS_HIGH(CH)) dut_a (
        .clk    (clk),
        .rst    (rst),
        .frm_if (ifa.slave),
        .sclk_o (sclk_a),
        .mosi_o (mosi_a),
        .cs_n_o (cs_n_a)
    );

    ledmatrix_spi_tx #(.WORD_W(WW), .CLK_DIV(1), .CS_HIGH(1)) dut_b (
        .clk    (clk),
        .rst    (rst),
        .frm_if (ifb.slave),
        .sclk_o (sclk_b),
        .mosi_o (mosi_b),
        .cs_n_o (cs_n_b)
    );

    int          total = 0;
    int          bad   = 0;
    int unsigned cyc   = 0;
    int          done_cnt = 0;
    logic [63:0] exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Issues a frame on DUT A; returns with valid still high, one cycle after accept.
    task automatic send_a(input logic [63:0] d, input bit expect_it, output int unsigned t0);
        int guard;
        guard = 0;
        ifa.data  = d;
        ifa.valid = 1'b1;
        if (expect_it) exp_q.push_back(d);
        forever begin
            @(negedge clk);
            if (ifa.ready && !rst) break;
            guard++;
            if (guard > 2000) begin
                $display("FAIL accept_timeout actual=none required=accept");
                $fatal(1, "accept timeout");
            end
        end
        @(posedge clk);
        #1;
        t0 = cyc;
    endtask

    task automatic wait_idle_a();
        int guard;
        guard = 0;
        while (!ifa.ready) begin
            @(negedge clk);
            guard++;
            if (guard > 2000) begin
                check("idle_timeout", 64'(ifa.ready), 64'd1);
                break;
            end
        end
    endtask

    // Monitor: decodes DUT A's serial stream and pops the scoreboard at every LOAD.
    logic        m_prev_sclk = 1'b0;
    logic        m_prev_cs_n = 1'b1;
    logic        m_prev_mosi = 1'b0;
    logic [63:0] m_word = '0;
    int          m_nbits = 0;
    int          m_hi_run = 0;
    bit          m_abort = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst && !cs_n_a) m_abort = 1'b1;
            if (!cs_n_a && sclk_a && !m_prev_sclk) begin
                m_word = {m_word[62:0], mosi_a};
                m_nbits++;
            end
            if (!cs_n_a && sclk_a && m_prev_sclk && !rst)
                check("mosi_stable_while_sclk_high", 64'(mosi_a), 64'(m_prev_mosi));
            if (cs_n_a && !m_prev_cs_n) begin
                if (m_abort) begin
                    check("done_after_abort", 64'(ifa.done), 64'd0);
                end else begin
                    check("done_at_cs_rise", 64'(ifa.done), 64'd1);
                    check("sclk_edge_count", 64'(m_nbits), 64'(WW));
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_frame actual=%h required=none", m_word);
                    end else begin
                        check("frame_word", m_word, exp_q.pop_front());
                    end
                end
                m_nbits = 0;
                m_word  = '0;
                m_abort = 1'b0;
            end else if (ifa.done) begin
                check("stray_done", 64'(ifa.done), 64'd0);
            end
            if (ifa.done) done_cnt++;
            if (cs_n_a && ifa.busy) begin
                m_hi_run++;
            end else begin
                if (m_hi_run != 0) check("cs_high_cycles", 64'(m_hi_run), 64'(CH));
                m_hi_run = 0;
            end
            m_prev_sclk = sclk_a;
            m_prev_cs_n = cs_n_a;
            m_prev_mosi = mosi_a;
        end
    end

    localparam logic [63:0] F2 = {4{c_ADDR_DECODE, 8'h00}};
    localparam logic [63:0] F3A = {4{c_ADDR_INTENSITY, 8'h0F}};
    localparam logic [63:0] F3B = {4{c_ADDR_SCANLIMIT, 8'h07}};
    localparam logic [63:0] F4 = {4{c_ADDR_SHUTDOWN, 8'h01}};
    localparam logic [63:0] F5 = {4{c_ADDR_TEST, 8'h00}};
    localparam logic [63:0] F6 = 64'h0123456789ABCDEF;

    initial begin
        int unsigned t0, ta, tb;
        int          dc0, rdy_seen, guard, rises;
        logic        prev;

        // Reset with valid asserted: nothing may start.
        ifa.valid = 1'b1;
        ifa.data  = 64'hDEADBEEFCAFEF00D;
        ifb.valid = 1'b0;
        ifb.data  = '0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("rst_cs_n", 64'(cs_n_a), 64'd1);
            check("rst_sclk", 64'(sclk_a), 64'd0);
            check("rst_mosi", 64'(mosi_a), 64'd0);
            check("rst_busy", 64'(ifa.busy), 64'd0);
            check("rst_done", 64'(ifa.done), 64'd0);
        end
        rst = 1'b0;
        ifa.valid = 1'b0;
        tick(1);
        check("post_rst_ready", 64'(ifa.ready), 64'd1);
        check("post_rst_busy", 64'(ifa.busy), 64'd0);
        check("post_rst_cs_n", 64'(cs_n_a), 64'd1);

        // Single frame with exact latency points.
        send_a(F2, 1'b1, t0);
        ifa.valid = 1'b0;
        check("t1_cs_n", 64'(cs_n_a), 64'd0);
        check("t1_busy", 64'(ifa.busy), 64'd1);
        check("t1_ready", 64'(ifa.ready), 64'd0);
        check("t1_sclk", 64'(sclk_a), 64'd0);
        tick(257);
        check("t258_cs_n", 64'(cs_n_a), 64'd0);
        check("t258_done", 64'(ifa.done), 64'd0);
        tick(1);
        check("t259_cs_n", 64'(cs_n_a), 64'd1);
        check("t259_done", 64'(ifa.done), 64'd1);
        tick(1);
        check("t260_done", 64'(ifa.done), 64'd0);
        tick(2);
        check("t262_ready", 64'(ifa.ready), 64'd0);
        tick(1);
        check("t263_ready", 64'(ifa.ready), 64'd1);
        check("t263_busy", 64'(ifa.busy), 64'd0);
        check("t263_mosi_hold", 64'(mosi_a), 64'(F2[0]));
        tick(3);

        // Back-to-back with valid held high.
        dc0 = done_cnt;
        send_a(F3A, 1'b1, ta);
        send_a(F3B, 1'b1, tb);
        ifa.valid = 1'b0;
        check("b2b_accept_gap", 64'(tb - ta), 64'd263);
        wait_idle_a();
        tick(2);
        check("b2b_done_pulses", 64'(done_cnt - dc0), 64'd2);

        // Data and valid churn during a frame in flight.
        send_a(F4, 1'b1, t0);
        ifa.data = '1;
        rdy_seen = 0;
        guard = 0;
        while (!ifa.done && guard < 1000) begin
            @(negedge clk);
            if (ifa.ready) rdy_seen++;
            guard++;
        end
        check("busy_ready_low", 64'(rdy_seen), 64'd0);
        ifa.valid = 1'b0;
        wait_idle_a();
        tick(3);
        check("no_second_frame_cs_n", 64'(cs_n_a), 64'd1);
        check("no_second_frame_busy", 64'(ifa.busy), 64'd0);

        // Reset after the 20th sclk rise, then a clean frame.
        send_a({4{c_ADDR_SHUTDOWN, 8'h00}}, 1'b0, t0);
        ifa.valid = 1'b0;
        rises = 0;
        prev  = sclk_a;
        guard = 0;
        while (rises < 20 && guard < 1000) begin
            tick(1);
            if (sclk_a && !prev) rises++;
            prev = sclk_a;
            guard++;
        end
        check("rises_before_rst", 64'(rises), 64'd20);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("midrst_cs_n", 64'(cs_n_a), 64'd1);
        check("midrst_sclk", 64'(sclk_a), 64'd0);
        check("midrst_busy", 64'(ifa.busy), 64'd0);
        check("midrst_mosi", 64'(mosi_a), 64'd0);
        check("midrst_ready", 64'(ifa.ready), 64'd1);
        tick(2);
        send_a(F5, 1'b1, t0);
        ifa.valid = 1'b0;
        wait_idle_a();
        tick(3);

        // Fastest configuration on DUT B, decoded inline.
        begin
            logic [63:0] w;
            int nb, last_rise, bad_per, low_cnt, rdy_at, done_at;
            logic pv;
            w = '0; nb = 0; last_rise = 0; bad_per = 0; low_cnt = 0; rdy_at = 0; done_at = 0;
            ifb.data  = F6;
            ifb.valid = 1'b1;
            guard = 0;
            forever begin
                @(negedge clk);
                if (ifb.ready || guard > 100) break;
                guard++;
            end
            @(posedge clk);
            #1;
            ifb.valid = 1'b0;
            pv = 1'b0;
            for (int k = 1; k <= 200; k++) begin
                if (ifb.ready && rdy_at == 0) rdy_at = k;
                if (ifb.done && done_at == 0) done_at = k;
                if (!cs_n_b) low_cnt++;
                if (!cs_n_b && sclk_b && !pv) begin
                    w = {w[62:0], mosi_b};
                    nb++;
                    if (last_rise != 0 && (k - last_rise) != 2) bad_per++;
                    last_rise = k;
                end
                pv = sclk_b;
                if (rdy_at != 0) break;
                tick(1);
            end
            check("div1_word", w, F6);
            check("div1_edges", 64'(nb), 64'd64);
            check("div1_period_violations", 64'(bad_per), 64'd0);
            check("div1_cs_low_cycles", 64'(low_cnt), 64'd129);
            check("div1_done_at", 64'(done_at), 64'd130);
            check("div1_ready_at", 64'(rdy_at), 64'd131);
            check("div1_mosi_hold", 64'(mosi_b), 64'd1);
        end

        tick(4);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
